// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t     : arbiter FSM state (IDLE -> ACCESS -> DONE -> IDLE)
//   ARB_PORT_CPU    : port index of the CPU requester
//   ARB_PORT_LDR    : port index of the program loader / debug requester
//   MEM_ARB_NPORTS  : number of requesting ports
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    localparam int   MEM_ARB_NPORTS = 2;
    localparam logic ARB_PORT_CPU   = 1'b0;
    localparam logic ARB_PORT_LDR   = 1'b1;

endpackage

// File: rtl/mem_arbiter_picker.sv
// Grant picker for the memory arbiter (combinational).
// Chooses which requesting port wins when the arbiter is idle.
// Build option: MEM_ARB_ROUND_ROBIN_EN
//   defined     : on contention the port that did not own the last access wins
//   not defined : fixed priority, the CPU port always wins on contention
// Ports:
//   req         in  per-port request
//   last_owner  in  port that completed the most recent transaction
//   grant_valid out at least one port is requesting
//   grant_idx   out index of the winning port
module mem_arbiter_picker
    import mem_arbiter_pkg::*;
(
    input  logic [MEM_ARB_NPORTS-1:0] req,
    input  logic                      last_owner,
    output logic                      grant_valid,
    output logic                      grant_idx
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; keep the input visibly consumed.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = |req;
        grant_idx   = ARB_PORT_CPU;
        if (&req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_idx = ~last_owner;
`else
            grant_idx = ARB_PORT_CPU;
`endif
        end else if (req[ARB_PORT_LDR]) begin
            grant_idx = ARB_PORT_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing the single-port unified memory between the CPU (port 0)
// and the program loader / debug port (port 1).
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin contention
// handling in the picker; default is fixed CPU priority.
//
// Handshake (req/ack): a requester raises req[i] with we/addr/wdata stable
// and holds them until it sees ack[i], a single-cycle pulse in the DONE
// cycle. Requests are only sampled in IDLE; a req still high in the IDLE
// cycle after its ack starts a new transaction.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   req, we              per-port request and write enable (1 = store)
//   addr0/1, wdata0/1    per-port address and write data
//   ack                  one-cycle completion pulse to the granted port
//   rdata                registered load data, valid in the ack cycle
//   busy                 high in ACCESS and DONE
//   mem_addr/we/wdata    memory-side request (registered)
//   mem_rdata            memory read data
//   dbg_state            current FSM state, for observation
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int MEM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MEM_ARB_NPORTS-1:0] req,
    input  logic [MEM_ARB_NPORTS-1:0] we,
    input  logic [ADDR_W-1:0]         addr0,
    input  logic [ADDR_W-1:0]         addr1,
    input  logic [DATA_W-1:0]         wdata0,
    input  logic [DATA_W-1:0]         wdata1,
    output logic [MEM_ARB_NPORTS-1:0] ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic [DATA_W-1:0]         mem_rdata,
    output arb_state_t                dbg_state
);

    localparam int               CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    arb_state_t       state;
    logic             owner;
    logic             last_owner;
    logic             lat_we;
    logic [CNT_W-1:0] cnt;
    logic             grant_valid;
    logic             grant_idx;

    mem_arbiter_picker u_picker (
        .req         (req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            ack        <= '0;
            busy       <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rdata      <= '0;
            owner      <= ARB_PORT_CPU;
            last_owner <= ARB_PORT_LDR;
            lat_we     <= 1'b0;
            cnt        <= '0;
        end else begin
            // Pulses default low; set only on the cycle they belong to.
            ack    <= '0;
            mem_we <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        // mem_addr/mem_wdata double as the latched request fields.
                        owner     <= grant_idx;
                        lat_we    <= we[grant_idx];
                        mem_addr  <= grant_idx ? addr1 : addr0;
                        mem_wdata <= grant_idx ? wdata1 : wdata0;
                        // Single write strobe: only the first ACCESS cycle.
                        mem_we    <= we[grant_idx];
                        busy      <= 1'b1;
                        cnt       <= '0;
                        state     <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt == CNT_LAST) begin
                        cnt        <= '0;
                        ack[owner] <= 1'b1;
                        // Memory data has settled after MEM_LAT address cycles.
                        if (!lat_we) begin
                            rdata <= mem_rdata;
                        end
                        state <= ARB_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    last_owner <= owner;
                    busy       <= 1'b0;
                    state      <= ARB_IDLE;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (MEM_LAT=1 and MEM_LAT=3), each with
// its own memory array. Only the selected instance receives requests.
// Expected results come from a transaction-level model: winner choice from
// the arbitration rules, ack at idle+1+latency, memory contents and held
// read data kept in plain arrays.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    // clock / reset
    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic mem_fill = 1'b1;
    logic sel      = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic [1:0] req = '0;
    logic       f_we    [2];
    logic [7:0] f_addr  [2];
    logic [7:0] f_wdata [2];
    logic [1:0] we;
    assign we = {f_we[1], f_we[0]};

    logic [1:0] req_a, req_b;
    assign req_a = sel ? 2'b00 : req;
    assign req_b = sel ? req : 2'b00;

    // instance outputs
    logic [1:0] ack_a, ack_b;
    logic [7:0] rdata_a, rdata_b, maddr_a, maddr_b, mwdata_a, mwdata_b, mrdata_a, mrdata_b;
    logic       busy_a, busy_b, mwe_a, mwe_b;
    arb_state_t st_a, st_b;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we),
        .addr0(f_addr[0]), .addr1(f_addr[1]), .wdata0(f_wdata[0]), .wdata1(f_wdata[1]),
        .ack(ack_a), .rdata(rdata_a), .busy(busy_a), .mem_addr(maddr_a), .mem_we(mwe_a),
        .mem_wdata(mwdata_a), .mem_rdata(mrdata_a), .dbg_state(st_a)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MEM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we),
        .addr0(f_addr[0]), .addr1(f_addr[1]), .wdata0(f_wdata[0]), .wdata1(f_wdata[1]),
        .ack(ack_b), .rdata(rdata_b), .busy(busy_b), .mem_addr(maddr_b), .mem_we(mwe_b),
        .mem_wdata(mwdata_b), .mem_rdata(mrdata_b), .dbg_state(st_b)
    );

    // memories: filled with a fixed pattern during reset, written on mem_we
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    assign mrdata_a = mem_a[maddr_a];
    assign mrdata_b = mem_b[maddr_b];
    always @(posedge clk) begin
        if (mem_fill) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= 8'(i * 37 + 11);
                mem_b[i] <= 8'(i * 37 + 11);
            end
        end else begin
            if (mwe_a) mem_a[maddr_a] <= mwdata_a;
            if (mwe_b) mem_b[maddr_b] <= mwdata_b;
        end
    end

    // selected-instance view
    logic [1:0] ack_s;
    logic [7:0] rdata_s, maddr_s, mwdata_s;
    logic       busy_s, mwe_s;
    arb_state_t st_s;
    assign ack_s    = sel ? ack_b    : ack_a;
    assign rdata_s  = sel ? rdata_b  : rdata_a;
    assign maddr_s  = sel ? maddr_b  : maddr_a;
    assign mwdata_s = sel ? mwdata_b : mwdata_a;
    assign busy_s   = sel ? busy_b   : busy_a;
    assign mwe_s    = sel ? mwe_b    : mwe_a;
    assign st_s     = sel ? st_b     : st_a;

    // reference model state
    logic [7:0] m_mem   [2][256];
    logic [7:0] m_rdata [2];
    int         m_last  [2];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [1:0] m, input int last);
        if (m == 2'b11) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            return (last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        return m[0] ? 0 : 1;
    endfunction

    function automatic int lat_now();
        return sel ? LAT_B : LAT_A;
    endfunction

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_ack"},   32'(ack_s),    32'h0);
        chk({pfx, "_busy"},  32'(busy_s),   32'h0);
        chk({pfx, "_mwe"},   32'(mwe_s),    32'h0);
        chk({pfx, "_maddr"}, 32'(maddr_s),  32'h0);
        chk({pfx, "_mwdat"}, 32'(mwdata_s), 32'h0);
        chk({pfx, "_rdata"}, 32'(rdata_s),  32'h0);
        chk({pfx, "_state"}, 32'(st_s),     32'(ARB_IDLE));
    endtask

    // Driver: call just after a rising edge with the selected instance idle.
    // Holds req=mask for n_acks completions, checking every cycle.
    task automatic run_reqs(input logic [1:0] mask, input int n_acks);
        int t_idle;
        int exp_c;
        int w;
        t_idle = 0;
        req = mask;
        for (int k = 0; k < n_acks; k++) begin
            w = pick(mask, m_last[sel]);
            exp_c = t_idle + 1 + lat_now();
            for (int c = t_idle; c <= exp_c; c++) begin
                @(negedge clk);
                if (c == t_idle) begin
                    chk("idle_ack",  32'(ack_s),  32'h0);
                    chk("idle_busy", 32'(busy_s), 32'h0);
                end else if (c < exp_c) begin
                    chk("acc_ack",   32'(ack_s),   32'h0);
                    chk("acc_busy",  32'(busy_s),  32'h1);
                    chk("acc_state", 32'(st_s),    32'(ARB_ACCESS));
                    chk("acc_maddr", 32'(maddr_s), 32'(f_addr[w]));
                    chk("acc_mwe",   32'(mwe_s),   (c == t_idle + 1) ? 32'(f_we[w]) : 32'h0);
                    if (c == t_idle + 1 && f_we[w])
                        chk("acc_mwdata", 32'(mwdata_s), 32'(f_wdata[w]));
                end else begin
                    if (f_we[w]) m_mem[sel][f_addr[w]] = f_wdata[w];
                    else         m_rdata[sel] = m_mem[sel][f_addr[w]];
                    chk("done_ack",   32'(ack_s),   32'(2'b01 << w));
                    chk("done_busy",  32'(busy_s),  32'h1);
                    chk("done_mwe",   32'(mwe_s),   32'h0);
                    chk("done_rdata", 32'(rdata_s), 32'(m_rdata[sel]));
                end
            end
            m_last[sel] = w;
            t_idle = exp_c + 1;
        end
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("gap_ack",  32'(ack_s),  32'h0);
            chk("gap_busy", 32'(busy_s), 32'h0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [1:0] mask;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) m_mem[s][i] = 8'(i * 37 + 11);
            m_rdata[s] = 8'h00;
            m_last[s]  = 1;
        end
        for (int p = 0; p < 2; p++) begin
            f_we[p] = 1'b0; f_addr[p] = 8'h00; f_wdata[p] = 8'h00;
        end

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        sel = 1'b0; #1; check_reset_vals("rst_a");
        sel = 1'b1; #1; check_reset_vals("rst_b");
        @(posedge clk);
        #1;
        reset = 1'b0; mem_fill = 1'b0; sel = 1'b0;

        // store from loader port, then a second store used by the load below
        f_we[1] = 1'b1; f_addr[1] = 8'h20; f_wdata[1] = 8'h3C;
        run_reqs(2'b10, 1);
        f_addr[1] = 8'h10; f_wdata[1] = 8'hA5;
        run_reqs(2'b10, 1);

        // CPU load of 0x10
        f_we[0] = 1'b0; f_addr[0] = 8'h10;
        run_reqs(2'b01, 1);
        chk("t1_rdata_a5", 32'(rdata_s), 32'hA5);

        // back-to-back CPU loads with req held
        f_addr[0] = 8'h20;
        run_reqs(2'b01, 3);
        chk("t6_rdata_3c", 32'(rdata_s), 32'h3C);

        // reset in the first ACCESS cycle of a store
        f_we[1] = 1'b1; f_addr[1] = 8'h33; f_wdata[1] = 8'h5A;
        req = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("t5_mwe_before", 32'(mwe_s), 32'h1);
        reset = 1'b1;
        req = '0;
        @(posedge clk);
        #1;
        // the strobe was still high on the reset edge, so the write lands
        m_mem[0][8'h33] = 8'h5A;
        for (int s = 0; s < 2; s++) begin
            m_rdata[s] = 8'h00;
            m_last[s]  = 1;
        end
        check_reset_vals("t5");
        reset = 1'b0;
        idle_cycles(3);

        // contention with both requests held
        f_we[0] = 1'b0; f_addr[0] = 8'h20;
        f_we[1] = 1'b0; f_addr[1] = 8'h33;
        run_reqs(2'b11, 4);

        // MEM_LAT=3 instance load
        sel = 1'b1;
        f_we[0] = 1'b0; f_addr[0] = 8'h05;
        run_reqs(2'b01, 1);
        chk("t4_rdata", 32'(rdata_s), 32'hC4);

        // randomized traffic on both instances
        for (int it = 0; it < 40; it++) begin
            sel = 1'($urandom_range(0, 1));
            for (int p = 0; p < 2; p++) begin
                f_we[p]    = 1'($urandom_range(0, 1));
                f_addr[p]  = 8'($urandom_range(0, 15));
                f_wdata[p] = 8'($urandom_range(0, 255));
            end
            mask = 2'($urandom_range(1, 3));
            run_reqs(mask, $urandom_range(1, 3));
            idle_cycles($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
